// File: rtl/id_ex_stage_if.sv
// Bundle of the decode-side, forwarding, and ALU-side signals of the ID/EX pipeline register.
// master: the surrounding pipeline (decode, hazard/forward sources, ALU). slave: the stage.
interface id_ex_stage_if #(
  parameter int D_WIDTH = 32,
  parameter int OP_SIZE = 4,
  parameter int R_ADDR  = 5
);
  logic               id_valid;
  logic               id_ready;
  logic [OP_SIZE-1:0] id_alu_op;
  logic [R_ADDR-1:0]  id_rs1;
  logic [R_ADDR-1:0]  id_rs2;
  logic [R_ADDR-1:0]  id_rd;
  logic [D_WIDTH-1:0] id_rs1_data;
  logic [D_WIDTH-1:0] id_rs2_data;
  logic [D_WIDTH-1:0] id_imm;
  logic               id_use_imm;
  logic               id_reg_write;

  logic               exm_reg_write;
  logic [R_ADDR-1:0]  exm_rd;
  logic [D_WIDTH-1:0] exm_data;
  logic               mwb_reg_write;
  logic [R_ADDR-1:0]  mwb_rd;
  logic [D_WIDTH-1:0] mwb_data;

  logic               flush;

  logic               ex_ready;
  logic               ex_valid;
  logic [OP_SIZE-1:0] ex_alu_op;
  logic [D_WIDTH-1:0] ex_a;
  logic [D_WIDTH-1:0] ex_b;
  logic [D_WIDTH-1:0] ex_rs2_data;
  logic [R_ADDR-1:0]  ex_rd;
  logic               ex_reg_write;
  logic [1:0]         ex_fwd_a;
  logic [1:0]         ex_fwd_b;

  modport master (
    output id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_reg_write,
           exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data,
           flush, ex_ready,
    input  id_ready, ex_valid, ex_alu_op, ex_a, ex_b, ex_rs2_data, ex_rd,
           ex_reg_write, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_reg_write,
           exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data,
           flush, ex_ready,
    output id_ready, ex_valid, ex_alu_op, ex_a, ex_b, ex_rs2_data, ex_rd,
           ex_reg_write, ex_fwd_a, ex_fwd_b
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operand forwarding at capture time and presents
// registered ALU operation/operands under valid/ready with stall hold and flush.
module id_ex_stage #(
  parameter int D_WIDTH = 32,
  parameter int OP_SIZE = 4,
  parameter int R_ADDR  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXM = 2'd1;
  localparam logic [1:0] FWD_MWB = 2'd2;

  logic               ex_valid_q;
  logic [OP_SIZE-1:0] ex_alu_op_q;
  logic [D_WIDTH-1:0] ex_a_q;
  logic [D_WIDTH-1:0] ex_b_q;
  logic [D_WIDTH-1:0] ex_rs2_data_q;
  logic [R_ADDR-1:0]  ex_rd_q;
  logic               ex_reg_write_q;
  logic [1:0]         ex_fwd_a_q;
  logic [1:0]         ex_fwd_b_q;

  logic               id_ready_w;
  logic               transfer;
  logic [D_WIDTH-1:0] rs1_fwd;
  logic [D_WIDTH-1:0] rs2_fwd;
  logic [1:0]         rs1_src;
  logic [1:0]         rs2_src;

  assign id_ready_w = bus.ex_ready | ~ex_valid_q;
  assign transfer   = bus.id_valid & id_ready_w;

  // EX/MEM wins over MEM/WB; register 0 never takes a forwarded value.
  always_comb begin
    rs1_src = FWD_RF;
    rs1_fwd = bus.id_rs1_data;
    if (bus.exm_reg_write && (bus.exm_rd == bus.id_rs1) && (bus.id_rs1 != '0)) begin
      rs1_src = FWD_EXM;
      rs1_fwd = bus.exm_data;
    end else if (bus.mwb_reg_write && (bus.mwb_rd == bus.id_rs1) && (bus.id_rs1 != '0)) begin
      rs1_src = FWD_MWB;
      rs1_fwd = bus.mwb_data;
    end
  end

  always_comb begin
    rs2_src = FWD_RF;
    rs2_fwd = bus.id_rs2_data;
    if (bus.exm_reg_write && (bus.exm_rd == bus.id_rs2) && (bus.id_rs2 != '0)) begin
      rs2_src = FWD_EXM;
      rs2_fwd = bus.exm_data;
    end else if (bus.mwb_reg_write && (bus.mwb_rd == bus.id_rs2) && (bus.id_rs2 != '0)) begin
      rs2_src = FWD_MWB;
      rs2_fwd = bus.mwb_data;
    end
  end

  // Flush beats capture: a same-cycle transfer is accepted but dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_alu_op_q    <= '0;
      ex_a_q         <= '0;
      ex_b_q         <= '0;
      ex_rs2_data_q  <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_fwd_a_q     <= FWD_RF;
      ex_fwd_b_q     <= FWD_RF;
    end else if (bus.flush) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end else if (transfer) begin
      ex_valid_q     <= 1'b1;
      ex_alu_op_q    <= bus.id_alu_op;
      ex_a_q         <= rs1_fwd;
      ex_b_q         <= bus.id_use_imm ? bus.id_imm : rs2_fwd;
      ex_rs2_data_q  <= rs2_fwd;
      ex_rd_q        <= bus.id_rd;
      ex_reg_write_q <= bus.id_reg_write;
      ex_fwd_a_q     <= rs1_src;
      ex_fwd_b_q     <= rs2_src;
    end else if (bus.ex_ready) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end
  end

  assign bus.id_ready     = id_ready_w;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_alu_op    = ex_alu_op_q;
  assign bus.ex_a         = ex_a_q;
  assign bus.ex_b         = ex_b_q;
  assign bus.ex_rs2_data  = ex_rs2_data_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_fwd_a     = ex_fwd_a_q;
  assign bus.ex_fwd_b     = ex_fwd_b_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  ex_t  got;
  ex_t  exp_ex;

  id_ex_stage_if #(.D_WIDTH(32), .OP_SIZE(4), .R_ADDR(5)) bus ();

  id_ex_stage #(.D_WIDTH(32), .OP_SIZE(4), .R_ADDR(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb got = {bus.ex_valid, bus.ex_alu_op, bus.ex_a, bus.ex_b, bus.ex_rs2_data,
                     bus.ex_rd, bus.ex_reg_write, bus.ex_fwd_a, bus.ex_fwd_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_alu_op = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
    bus.id_reg_write = 0; bus.exm_reg_write = 0; bus.exm_rd = 0; bus.exm_data = 0;
    bus.mwb_reg_write = 0; bus.mwb_rd = 0; bus.mwb_data = 0; bus.flush = 0; bus.ex_ready = 1;
  endtask

  task automatic set_id(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic use_imm, input logic rw);
    bus.id_valid = 1; bus.id_alu_op = op; bus.id_rs1 = rs1; bus.id_rs1_data = d1;
    bus.id_rs2 = rs2; bus.id_rs2_data = d2; bus.id_rd = rd; bus.id_imm = imm;
    bus.id_use_imm = use_imm; bus.id_reg_write = rw;
  endtask

  // Reference forwarding: the youngest writer of a nonzero register supplies the value.
  function automatic logic [33:0] resolve(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return {2'd0, rf};
    if (bus.exm_reg_write && bus.exm_rd == r) return {2'd1, bus.exm_data};
    if (bus.mwb_reg_write && bus.mwb_rd == r) return {2'd2, bus.mwb_data};
    return {2'd0, rf};
  endfunction

  function automatic ex_t model_capture();
    ex_t e;
    logic [33:0] ra, rb;
    ra = resolve(bus.id_rs1, bus.id_rs1_data);
    rb = resolve(bus.id_rs2, bus.id_rs2_data);
    e.valid = 1; e.op = bus.id_alu_op; e.a = ra[31:0];
    e.rs2 = rb[31:0]; e.b = bus.id_use_imm ? bus.id_imm : rb[31:0];
    e.rd = bus.id_rd; e.rw = bus.id_reg_write; e.fa = ra[33:32]; e.fb = rb[33:32];
    return e;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    checks++;
    if (got !== '0) $display("FAIL reset_outputs: got %h want 0", got);
    else passed++;
    checks++;
    if (bus.id_ready !== 1'b1) $display("FAIL reset_id_ready: got %b want 1", bus.id_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    clear_inputs();
    set_id(4'b0001, 5'd3, 32'd10, 5'd4, 32'd7, 5'd8, 32'd0, 1'b0, 1'b1);
    tick();
    exp_ex = '{valid:1, op:4'b0001, a:32'd10, b:32'd7, rs2:32'd7, rd:5'd8, rw:1, fa:0, fb:0};
    checks++;
    if (got !== exp_ex) $display("FAIL basic_capture: got %h want %h", got, exp_ex);
    else passed++;
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    set_id(4'd2, 5'd5, 32'd1, 5'd2, 32'd3, 5'd9, 32'd0, 1'b0, 1'b1);
    bus.exm_reg_write = 1; bus.exm_rd = 5; bus.exm_data = 32'hAA;
    bus.mwb_reg_write = 1; bus.mwb_rd = 5; bus.mwb_data = 32'hBB;
    tick();
    checks++;
    if ({bus.ex_a, bus.ex_fwd_a} !== {32'hAA, 2'd1})
      $display("FAIL fwd_exm_priority: got a=%h code=%0d want a=aa code=1", bus.ex_a, bus.ex_fwd_a);
    else passed++;
    bus.exm_reg_write = 0;
    tick();
    checks++;
    if ({bus.ex_a, bus.ex_fwd_a, bus.ex_b} !== {32'hBB, 2'd2, 32'd3})
      $display("FAIL fwd_mwb: got a=%h code=%0d b=%h want a=bb code=2 b=3", bus.ex_a, bus.ex_fwd_a, bus.ex_b);
    else passed++;
  endtask

  task automatic test_reg_zero();
    clear_inputs();
    set_id(4'd3, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd0, 1'b0, 1'b1);
    bus.exm_reg_write = 1; bus.exm_rd = 0; bus.exm_data = 32'h55;
    bus.mwb_reg_write = 1; bus.mwb_rd = 0; bus.mwb_data = 32'h66;
    tick();
    checks++;
    if ({bus.ex_a, bus.ex_fwd_a, bus.ex_b, bus.ex_fwd_b} !== {32'd0, 2'd0, 32'd0, 2'd0})
      $display("FAIL reg_zero: got a=%h fa=%0d b=%h fb=%0d want all 0", bus.ex_a, bus.ex_fwd_a, bus.ex_b, bus.ex_fwd_b);
    else passed++;
  endtask

  task automatic test_imm();
    clear_inputs();
    set_id(4'd4, 5'd1, 32'd2, 5'd6, 32'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 1'b1);
    bus.exm_reg_write = 1; bus.exm_rd = 7; bus.exm_data = 32'h77;
    bus.mwb_reg_write = 1; bus.mwb_rd = 6; bus.mwb_data = 32'd9;
    tick();
    checks++;
    if ({bus.ex_b, bus.ex_rs2_data, bus.ex_fwd_b} !== {32'hFFFF_FFFC, 32'd9, 2'd2})
      $display("FAIL imm_select: got b=%h rs2=%h fb=%0d want b=fffffffc rs2=9 fb=2", bus.ex_b, bus.ex_rs2_data, bus.ex_fwd_b);
    else passed++;
  endtask

  task automatic test_hold();
    ex_t a_exp;
    ex_t b_exp;
    clear_inputs();
    set_id(4'd5, 5'd10, 32'h100, 5'd11, 32'h200, 5'd12, 32'd0, 1'b0, 1'b1);
    a_exp = model_capture();
    tick();
    bus.ex_ready = 0;
    set_id(4'd6, 5'd13, 32'h300, 5'd14, 32'h400, 5'd15, 32'h5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.exm_reg_write = 1; bus.exm_rd = 5'd13; bus.exm_data = $urandom;
      bus.mwb_reg_write = 1; bus.mwb_rd = 5'd14; bus.mwb_data = $urandom;
      #1;
      checks++;
      if (bus.id_ready !== 1'b0) $display("FAIL hold_id_ready: cycle %0d got %b want 0", i, bus.id_ready);
      else passed++;
      tick();
      checks++;
      if (got !== a_exp) $display("FAIL hold_stable: cycle %0d got %h want %h", i, got, a_exp);
      else passed++;
    end
    bus.ex_ready = 1;
    bus.exm_data = 32'hC0DE; bus.mwb_data = 32'hBEEF;
    b_exp = model_capture();
    tick();
    checks++;
    if (got !== b_exp) $display("FAIL hold_release: got %h want %h", got, b_exp);
    else passed++;
  endtask

  task automatic test_flush();
    clear_inputs();
    set_id(4'd7, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'd0, 1'b0, 1'b1);
    tick();
    bus.ex_ready = 0;
    set_id(4'd8, 5'd4, 32'd4, 5'd5, 32'd5, 5'd6, 32'd0, 1'b0, 1'b1);
    tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    #1;
    checks++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.id_ready} !== 3'b001)
      $display("FAIL flush_hold: got v=%b rw=%b rdy=%b want 0 0 1", bus.ex_valid, bus.ex_reg_write, bus.id_ready);
    else passed++;
    bus.flush = 1;
    #1;
    checks++;
    if (bus.id_ready !== 1'b1) $display("FAIL flush_ready_unaffected: got %b want 1", bus.id_ready);
    else passed++;
    tick();
    bus.flush = 0;
    bus.id_valid = 0;
    checks++;
    if ({bus.ex_valid, bus.ex_reg_write} !== 2'b00)
      $display("FAIL flush_discard_transfer: got v=%b rw=%b want 0 0", bus.ex_valid, bus.ex_reg_write);
    else passed++;
  endtask

  task automatic test_reset_mid_hold();
    clear_inputs();
    set_id(4'd9, 5'd7, 32'h77, 5'd8, 32'h88, 5'd9, 32'd0, 1'b0, 1'b1);
    tick();
    bus.ex_ready = 0;
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({got, bus.id_ready} !== {111'd0, 1'b1})
      $display("FAIL reset_mid_hold: got %h rdy=%b want 0 rdy=1", got, bus.id_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    ex_t m;
    logic exp_rdy;
    m = '0;
    clear_inputs();
    for (int n = 0; n < 300; n++) begin
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.ex_ready = ($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.id_alu_op = 4'($urandom); bus.id_rd = 5'($urandom);
      bus.id_rs1 = 5'($urandom_range(0, 5)); bus.id_rs2 = 5'($urandom_range(0, 5));
      bus.id_rs1_data = (bus.id_rs1 == 0) ? 32'd0 : $urandom;
      bus.id_rs2_data = (bus.id_rs2 == 0) ? 32'd0 : $urandom;
      bus.id_imm = $urandom; bus.id_use_imm = 1'($urandom); bus.id_reg_write = 1'($urandom);
      bus.exm_reg_write = 1'($urandom); bus.exm_rd = 5'($urandom_range(0, 5)); bus.exm_data = $urandom;
      bus.mwb_reg_write = 1'($urandom); bus.mwb_rd = 5'($urandom_range(0, 5)); bus.mwb_data = $urandom;
      #1;
      exp_rdy = bus.ex_ready || !m.valid;
      checks++;
      if (bus.id_ready !== exp_rdy) $display("FAIL rand_id_ready: step %0d got %b want %b", n, bus.id_ready, exp_rdy);
      else passed++;
      if (bus.flush) begin
        m.valid = 0; m.rw = 0;
      end else if (bus.id_valid && exp_rdy) begin
        m = model_capture();
      end else if (bus.ex_ready) begin
        m.valid = 0; m.rw = 0;
      end
      tick();
      checks++;
      if (m.valid) begin
        if (got !== m) $display("FAIL rand_ex: step %0d got %h want %h", n, got, m);
        else passed++;
      end else begin
        if ({bus.ex_valid, bus.ex_reg_write} !== 2'b00)
          $display("FAIL rand_idle: step %0d got v=%b rw=%b want 0 0", n, bus.ex_valid, bus.ex_reg_write);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fwd_priority();
    test_reg_zero();
    test_imm();
    test_hold();
    test_flush();
    test_random();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Pipeline register between instruction decode and the ALU. It captures the decoded operation and operands, resolves operand forwarding from the two downstream stages, and selects register or immediate for ALU operand b. It presents a stable, registered alu_op/a/b to the ALU under a valid/ready handshake with stall backpressure and flush.

Parameters:
D_WIDTH, 32, datapath width of operands and forwarded results
OP_SIZE, 4, width of the ALU operation select
R_ADDR, 5, register index width (register 0 is hardwired zero)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decode presents an instruction
id_ready  output  1  stage can accept this cycle
id_alu_op  input  OP_SIZE  decoded ALU operation
id_rs1  input  R_ADDR  source register 1 index
id_rs2  input  R_ADDR  source register 2 index
id_rd  input  R_ADDR  destination register index
id_rs1_data  input  D_WIDTH  register file read data 1
id_rs2_data  input  D_WIDTH  register file read data 2
id_imm  input  D_WIDTH  sign-extended immediate
id_use_imm  input  1  1: operand b = immediate
id_reg_write  input  1  instruction writes rd
exm_reg_write  input  1  EX/MEM result will be written
exm_rd  input  R_ADDR  EX/MEM destination
exm_data  input  D_WIDTH  EX/MEM result
mwb_reg_write  input  1  MEM/WB result will be written
mwb_rd  input  R_ADDR  MEM/WB destination
mwb_data  input  D_WIDTH  MEM/WB result
flush  input  1  squash held and incoming instruction
ex_ready  input  1  ALU stage consumes ex_* this cycle
ex_valid  output  1  ex_* hold a live instruction
ex_alu_op  output  OP_SIZE  registered ALU operation
ex_a  output  D_WIDTH  registered operand a
ex_b  output  D_WIDTH  registered operand b
ex_rs2_data  output  D_WIDTH  forwarded rs2 value (store data)
ex_rd  output  R_ADDR  registered destination
ex_reg_write  output  1  registered write enable, forced 0 when ex_valid=0
ex_fwd_a  output  2  forward source of a: 0 RF, 1 EX/MEM, 2 MEM/WB
ex_fwd_b  output  2  forward source of rs2 value, same encoding

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs 0, ex_alu_op = 0, ex_valid = 0. id_ready = 1 immediately after reset.
- id_ready = ex_ready | ~ex_valid (combinational). Transfer occurs when id_valid & id_ready at a rising edge.
- On transfer: register all ex_* from the forwarded values; ex_valid <= 1. Latency: one cycle, decode to ALU inputs.
- ex_valid & ~ex_ready with no flush: hold. Every ex_* output stays bit-identical. id_ready = 0.
- ex_ready & ~(id_valid & id_ready): ex_valid <= 0. Data registers may keep old values; ex_reg_write <= 0.
- Forwarding is computed combinationally at capture time, per source register r:
  - if exm_reg_write & exm_rd==r & r!=0 -> exm_data, code 1
  - else if mwb_reg_write & mwb_rd==r & r!=0 -> mwb_data, code 2
  - else the RF data, code 0
  - EX/MEM has priority when both match.
- Register 0: a forwarded value is never used for index 0. The RF data for index 0 passes through (RF returns zero).
- ex_a = forwarded rs1. ex_rs2_data = forwarded rs2. ex_b = id_imm if id_use_imm, else forwarded rs2. ex_fwd_b reflects rs2 forwarding regardless of id_use_imm.
- Load-use hazards are resolved by the external hazard unit deasserting id_valid. This stage does not detect them.
- Flush has priority over hold and capture. Next edge: ex_valid <= 0 and ex_reg_write <= 0. An id transfer in the same cycle is accepted (id_ready unaffected) and discarded.
- Reset mid-hold or mid-transfer: outputs go to reset values at once; the in-flight instruction is lost.
- No arithmetic on data; widths pass through unchanged.

Test Plan:
- Reset, then id_valid=1, alu_op=0001, rs1=3 data 10, rs2=4 data 7, use_imm=0, no forwards -> next cycle ex_valid=1, ex_a=10, ex_b=7, ex_fwd_a=0, ex_fwd_b=0.
- rs1=5 with exm_reg_write=1, exm_rd=5, exm_data=0xAA, and also mwb_rd=5, mwb_data=0xBB -> ex_a=0xAA, ex_fwd_a=1. With exm_reg_write=0 -> ex_a=0xBB, ex_fwd_a=2.
- rs1=0, exm_rd=0, exm_reg_write=1, exm_data=0x55, id_rs1_data=0 -> ex_a=0, ex_fwd_a=0.
- use_imm=1, imm=0xFFFFFFFC, rs2=6 forwarded from MEM/WB value 9 -> ex_b=0xFFFFFFFC, ex_rs2_data=9, ex_fwd_b=2.
- Capture A, hold ex_ready=0 for 3 cycles with a new B on id and changing forward inputs -> ex_* stay A, id_ready=0. Raise ex_ready -> B appears next cycle.
- Assert flush while holding with id_valid=1 -> next cycle ex_valid=0, ex_reg_write=0, id_ready=1. Pull rst_n low mid-hold -> all outputs 0 asynchronously.
